// File: rtl/ahb_master_arbiter_if.sv
// Arbiter request/grant bundle: owner-side request/control inputs and the one-hot mux selects.
// The master modport is the arbiter (drives the selects); slave is the fabric/requester side.
interface ahb_master_arbiter_if #(
    parameter int NM = 16
);
    logic [NM-1:0] req;
    logic [NM-1:0] lock;
    logic [1:0]    htrans;
    logic [2:0]    hburst;
    logic          hready;
    logic [NM-1:0] addr_sel;
    logic [NM-1:0] data_sel;
    logic [3:0]    hmaster;
    logic          hmastlock;
    logic [1:0]    dbg_state;
    logic [3:0]    dbg_rem;

    modport master (
        input  req, lock, htrans, hburst, hready,
        output addr_sel, data_sel, hmaster, hmastlock, dbg_state, dbg_rem
    );

    modport slave (
        output req, lock, htrans, hburst, hready,
        input  addr_sel, data_sel, hmaster, hmastlock, dbg_state, dbg_rem
    );
endinterface

// File: rtl/ahb_master_arbiter.sv
// AHB-lite multi-master arbiter: one-hot address/data mux selects, burst-aware and lock-aware
// ownership changes. Handshake: a transfer is accepted on a rising HCLK edge with hready = 1.
module ahb_master_arbiter #(
    parameter int NM             = 16,
    parameter int DEFAULT_MASTER = 0,
    parameter bit RR_EN          = 1'b1
) (
    input logic                  HCLK,
    input logic                  HRESETn,
    ahb_master_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_OWN  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;
    localparam logic [2:0] HB_SINGLE = 3'd0;
    localparam logic [2:0] HB_INCR   = 3'd1;
    localparam logic [3:0] DEF_IDX   = 4'(DEFAULT_MASTER);

    function automatic logic [NM-1:0] onehot(input logic [3:0] idx);
        onehot = {{(NM-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [3:0] burst_len(input logic [2:0] hb);
        case (hb)
            3'd2, 3'd3: burst_len = 4'd3;
            3'd4, 3'd5: burst_len = 4'd7;
            3'd6, 3'd7: burst_len = 4'd15;
            default:    burst_len = 4'd0;
        endcase
    endfunction

    state_t        state_q;
    logic [NM-1:0] addr_sel_q;
    logic [NM-1:0] data_sel_q;
    logic [3:0]    hmaster_q;
    logic [3:0]    rr_ptr_q;
    logic [3:0]    rem_q;

    logic          owner_lock;
    logic          ap;
    logic          lock_entry;
    logic [3:0]    win_idx;
    logic          win_found;
    int            cand;

    assign owner_lock = |(addr_sel_q & bus.lock);

    // Round-robin starts one past the last real winner; fixed priority scans from index 0.
    always_comb begin
        win_idx   = DEF_IDX;
        win_found = 1'b0;
        cand      = 0;
        for (int k = 0; k < NM; k++) begin
            cand = RR_EN ? (int'(rr_ptr_q) + 1 + k) % NM : k;
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = 4'(cand);
            end
        end
    end

    always_comb begin
        ap = 1'b0;
        if (bus.hready && !owner_lock) begin
            if (state_q == ST_LOCK || state_q == ST_PARK) begin
                ap = (state_q == ST_LOCK) || (bus.htrans != HT_BUSY);
            end else begin
                case (bus.htrans)
                    HT_IDLE:   ap = 1'b1;
                    HT_NONSEQ: ap = (bus.hburst == HB_SINGLE) || (bus.hburst == HB_INCR);
                    HT_SEQ:    ap = (bus.hburst == HB_INCR) || (rem_q == 4'd1);
                    default:   ap = 1'b0;
                endcase
            end
        end
    end

    // A locked NONSEQ from the current owner freezes the grant instead of arbitrating.
    assign lock_entry = bus.hready && owner_lock && (state_q == ST_OWN) && (bus.htrans == HT_NONSEQ);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_PARK;
            addr_sel_q <= onehot(DEF_IDX);
            data_sel_q <= onehot(DEF_IDX);
            hmaster_q  <= DEF_IDX;
            rr_ptr_q   <= DEF_IDX;
            rem_q      <= 4'd0;
        end else if (bus.hready) begin
            data_sel_q <= addr_sel_q;
            if (bus.htrans == HT_NONSEQ) begin
                rem_q <= burst_len(bus.hburst);
            end else if (bus.htrans == HT_SEQ && rem_q != 4'd0) begin
                rem_q <= rem_q - 4'd1;
            end
            if (lock_entry) begin
                state_q <= ST_LOCK;
            end else if (ap) begin
                addr_sel_q <= onehot(win_idx);
                hmaster_q  <= win_idx;
                if (win_found) begin
                    rr_ptr_q <= win_idx;
                end
                state_q <= win_found ? ST_OWN : ST_PARK;
            end
        end
    end

    assign bus.addr_sel  = addr_sel_q;
    assign bus.data_sel  = data_sel_q;
    assign bus.hmaster   = hmaster_q;
    assign bus.hmastlock = |(addr_sel_q & bus.lock);
    assign bus.dbg_state = state_q;
    assign bus.dbg_rem   = rem_q;
endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench: round-robin arbiter (NM=16, default 3) plus a fixed-priority instance (NM=8, default 0).
module tb_ahb_master_arbiter;
    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_master_arbiter_if #(.NM(16)) bif ();
    ahb_master_arbiter_if #(.NM(8))  fif ();

    ahb_master_arbiter #(.NM(16), .DEFAULT_MASTER(3), .RR_EN(1'b1)) u_dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bif.master)
    );

    ahb_master_arbiter #(.NM(8), .DEFAULT_MASTER(0), .RR_EN(1'b0)) u_fix (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (fif.master)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] r, input logic [1:0] t, input logic [2:0] b);
        bif.req    = r;
        bif.htrans = t;
        bif.hburst = b;
    endtask

    initial begin
        #50000;
        $error("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        bif.req = '0; bif.lock = '0; bif.htrans = 2'd0; bif.hburst = 3'd0; bif.hready = 1'b1;
        fif.req = '0; fif.lock = '0; fif.htrans = 2'd0; fif.hburst = 3'd0; fif.hready = 1'b1;

        // reset state
        #12;
        chk("rst_addr_sel", bif.addr_sel, 16'h0008);
        chk("rst_data_sel", bif.data_sel, 16'h0008);
        chk("rst_hmaster", 16'(bif.hmaster), 16'd3);
        chk("rst_hmastlock", 16'(bif.hmastlock), 16'd0);
        chk("rst_state", 16'(bif.dbg_state), 16'd0);
        chk("rst_rem", 16'(bif.dbg_rem), 16'd0);
        chk("fix_rst_addr_sel", 16'(fif.addr_sel), 16'h0001);
        HRESETn = 1'b1;
        step();
        chk("park_idle_hold", bif.addr_sel, 16'h0008);

        // round-robin from pointer 3 with masters 1 and 4 requesting
        drive(16'h0012, 2'd0, 3'd0);
        step();
        chk("rr_grant_m4", bif.addr_sel, 16'h0010);
        chk("rr_hmaster_m4", 16'(bif.hmaster), 16'd4);
        chk("rr_state_own", 16'(bif.dbg_state), 16'd1);
        chk("rr_data_lag", bif.data_sel, 16'h0008);
        step();
        chk("rr_data_m4", bif.data_sel, 16'h0010);
        chk("rr_grant_m1", bif.addr_sel, 16'h0002);
        step();
        chk("rr_grant_m4_again", bif.addr_sel, 16'h0010);
        chk("rr_data_m1", bif.data_sel, 16'h0002);

        // master 2 INCR4 with master 5 waiting, two wait states on beat 2
        drive(16'h0004, 2'd0, 3'd0);
        step();
        chk("b4_grant_m2", bif.addr_sel, 16'h0004);
        drive(16'h0024, 2'd2, 3'd3);
        step();
        chk("b4_beat1_addr", bif.addr_sel, 16'h0004);
        chk("b4_beat1_rem", 16'(bif.dbg_rem), 16'd3);
        drive(16'h0024, 2'd3, 3'd3);
        bif.hready = 1'b0;
        step();
        step();
        chk("b4_stall_addr", bif.addr_sel, 16'h0004);
        chk("b4_stall_data", bif.data_sel, 16'h0004);
        chk("b4_stall_rem", 16'(bif.dbg_rem), 16'd3);
        bif.hready = 1'b1;
        step();
        chk("b4_beat2_rem", 16'(bif.dbg_rem), 16'd2);
        step();
        chk("b4_beat3_addr", bif.addr_sel, 16'h0004);
        chk("b4_beat3_rem", 16'(bif.dbg_rem), 16'd1);
        step();
        chk("b4_beat4_grant_m5", bif.addr_sel, 16'h0020);
        chk("b4_beat4_hmaster", 16'(bif.hmaster), 16'd5);
        chk("b4_beat4_data", bif.data_sel, 16'h0004);

        // locked sequence by master 1 with masters 0 and 7 requesting
        drive(16'h0002, 2'd0, 3'd0);
        step();
        chk("lk_grant_m1", bif.addr_sel, 16'h0002);
        bif.lock = 16'h0002;
        drive(16'h0083, 2'd2, 3'd0);
        step();
        chk("lk_state", 16'(bif.dbg_state), 16'd2);
        chk("lk_hmastlock", 16'(bif.hmastlock), 16'd1);
        chk("lk_addr", bif.addr_sel, 16'h0002);
        drive(16'h0083, 2'd0, 3'd0);
        step();
        chk("lk_hold1", bif.addr_sel, 16'h0002);
        drive(16'h0083, 2'd2, 3'd0);
        step();
        chk("lk_hold2", bif.addr_sel, 16'h0002);
        drive(16'h0083, 2'd0, 3'd0);
        step();
        chk("lk_hold3", bif.addr_sel, 16'h0002);
        chk("lk_hold3_state", 16'(bif.dbg_state), 16'd2);
        bif.lock = 16'h0000;
        #1;
        chk("lk_drop_hmastlock", 16'(bif.hmastlock), 16'd0);
        step();
        chk("lk_exit_grant_m7", bif.addr_sel, 16'h0080);
        chk("lk_exit_state", 16'(bif.dbg_state), 16'd1);

        // master 6 INCR8 with a BUSY beat, master 0 waiting
        drive(16'h0040, 2'd0, 3'd0);
        step();
        chk("b8_grant_m6", bif.addr_sel, 16'h0040);
        drive(16'h0041, 2'd2, 3'd5);
        step();
        chk("b8_nonseq_rem", 16'(bif.dbg_rem), 16'd7);
        drive(16'h0041, 2'd3, 3'd5);
        step();
        chk("b8_seq1_rem", 16'(bif.dbg_rem), 16'd6);
        drive(16'h0041, 2'd1, 3'd5);
        step();
        chk("b8_busy_rem", 16'(bif.dbg_rem), 16'd6);
        chk("b8_busy_addr", bif.addr_sel, 16'h0040);
        drive(16'h0041, 2'd3, 3'd5);
        for (int i = 0; i < 5; i++) step();
        chk("b8_last_rem", 16'(bif.dbg_rem), 16'd1);
        chk("b8_last_addr", bif.addr_sel, 16'h0040);
        step();
        chk("b8_end_grant_m0", bif.addr_sel, 16'h0001);
        chk("b8_end_rem", 16'(bif.dbg_rem), 16'd0);

        // reset in the middle of a master 9 INCR16
        drive(16'h0200, 2'd0, 3'd0);
        step();
        chk("b16_grant_m9", bif.addr_sel, 16'h0200);
        drive(16'h0200, 2'd2, 3'd7);
        step();
        drive(16'h0200, 2'd3, 3'd7);
        step();
        chk("b16_rem", 16'(bif.dbg_rem), 16'd14);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_addr_sel", bif.addr_sel, 16'h0008);
        chk("mid_rst_data_sel", bif.data_sel, 16'h0008);
        chk("mid_rst_hmaster", 16'(bif.hmaster), 16'd3);
        chk("mid_rst_state", 16'(bif.dbg_state), 16'd0);
        chk("mid_rst_rem", 16'(bif.dbg_rem), 16'd0);
        drive(16'h0000, 2'd0, 3'd0);
        step();
        HRESETn = 1'b1;

        // fixed priority: lowest requesting index wins every arbitration point
        fif.req = 8'h82;
        step();
        chk("fix_grant_m1", 16'(fif.addr_sel), 16'h0002);
        chk("fix_state_own", 16'(fif.dbg_state), 16'd1);
        fif.req = 8'h83;
        step();
        chk("fix_grant_m0", 16'(fif.addr_sel), 16'h0001);
        fif.req = 8'h82;
        step();
        chk("fix_grant_m1_again", 16'(fif.addr_sel), 16'h0002);
        chk("fix_hmaster", 16'(fif.hmaster), 16'd1);
        fif.req = 8'h00;
        step();
        chk("fix_park_addr", 16'(fif.addr_sel), 16'h0001);
        chk("fix_park_state", 16'(fif.dbg_state), 16'd0);
        chk("fix_park_data", 16'(fif.data_sel), 16'h0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
